// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state and
// instruction-class encodings, datapath select codes and decoder bit positions.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_RALU,
        CLS_IALU,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_J,
        CLS_JR,
        CLS_JAL
    } inst_class_t;

    // PC source select
    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    // Register-file write address select
    localparam logic [1:0] RF_WSEL_RD = 2'd0;
    localparam logic [1:0] RF_WSEL_RT = 2'd1;
    localparam logic [1:0] RF_WSEL_RA = 2'd2;

    // Write-back data select
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC  = 2'd2;

    // Decoder one-hot bit positions
    localparam int INST_W  = 27;
    localparam int IT_ADD  = 0;
    localparam int IT_SLT  = 14;
    localparam int IT_ADDI = 15;
    localparam int IT_XORI = 19;
    localparam int IT_LW   = 20;
    localparam int IT_SW   = 21;
    localparam int IT_BEQ  = 22;
    localparam int IT_BNE  = 23;
    localparam int IT_J    = 24;
    localparam int IT_JR   = 25;
    localparam int IT_JAL  = 26;

endpackage

// File: rtl/multicycle_ctrl_inst_class_enc.sv
// Maps the decoder one-hot onto a compact instruction class. BEQ and BNE share
// the branch class; br_ne tells them apart. none/multi flag bad one-hot words.
module inst_class_enc
    import mips_ctrl_pkg::*;
(
    input  logic [INST_W-1:0] inst_type,
    output inst_class_t       cls,
    output logic              br_ne,
    output logic              none,
    output logic              multi
);

    // Class lookup; class is meaningless when none or multi is set
    always_comb begin
        cls   = CLS_RALU;
        br_ne = 1'b0;
        none  = (inst_type == '0);
        multi = ((inst_type & (inst_type - INST_W'(1))) != '0);
        if (|inst_type[IT_SLT:IT_ADD]) begin
            cls = CLS_RALU;
        end else if (|inst_type[IT_XORI:IT_ADDI]) begin
            cls = CLS_IALU;
        end else if (inst_type[IT_LW]) begin
            cls = CLS_LW;
        end else if (inst_type[IT_SW]) begin
            cls = CLS_SW;
        end else if (inst_type[IT_BEQ] || inst_type[IT_BNE]) begin
            cls   = CLS_BR;
            br_ne = inst_type[IT_BNE];
        end else if (inst_type[IT_J]) begin
            cls = CLS_J;
        end else if (inst_type[IT_JR]) begin
            cls = CLS_JR;
        end else if (inst_type[IT_JAL]) begin
            cls = CLS_JAL;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT over a shared
// variable-latency memory port. Optional performance counters cyc_cnt/ret_cnt
// are built when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned NOP_SKIP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst_type,
    input  logic              inst_zero,
    input  logic              alu_zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_isel,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_src,
    output logic              alu_srcb_imm,
    output logic              rf_we,
    output logic [1:0]        rf_wsel,
    output logic [1:0]        wb_sel,
    output logic              halted,
    output logic              illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       ret_cnt
`endif
);

    state_t      state;
    state_t      state_next;
    inst_class_t cls_dec;
    inst_class_t cls_q;
    logic        br_ne_dec;
    logic        br_ne_q;
    logic        dec_none;
    logic        dec_multi;

    inst_class_enc u_enc (
        .inst_type (inst_type),
        .cls       (cls_dec),
        .br_ne     (br_ne_dec),
        .none      (dec_none),
        .multi     (dec_multi)
    );

    // State register, halt/illegal flags and the class latched in DECODE
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            halted  <= 1'b0;
            illegal <= 1'b0;
            cls_q   <= CLS_RALU;
            br_ne_q <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= (state_next == ST_HALT);
            if (state == ST_DECODE) begin
                cls_q   <= cls_dec;
                br_ne_q <= br_ne_dec;
                if (dec_multi) begin
                    illegal <= 1'b1;
                end
            end
        end
    end

    // Next state and datapath controls; everything is held low during reset
    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_isel     = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_PLUS4;
        alu_srcb_imm = 1'b0;
        rf_we        = 1'b0;
        rf_wsel      = RF_WSEL_RD;
        wb_sel       = WB_SEL_ALU;
        if (rst) begin
            state_next = ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_isel = 1'b1;
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        pc_we      = 1'b1;
                        pc_src     = PC_SRC_PLUS4;
                        state_next = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_none) begin
                        state_next = (inst_zero && (NOP_SKIP != 0)) ? ST_FETCH : ST_HALT;
                    end else if (dec_multi) begin
                        state_next = ST_HALT;
                    end else begin
                        state_next = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (cls_q)
                        CLS_RALU: state_next = ST_WB;
                        CLS_IALU: begin
                            alu_srcb_imm = 1'b1;
                            state_next   = ST_WB;
                        end
                        CLS_LW, CLS_SW: begin
                            alu_srcb_imm = 1'b1;
                            state_next   = ST_MEM;
                        end
                        CLS_BR: begin
                            // BEQ takes on zero, BNE on non-zero
                            if (alu_zero ^ br_ne_q) begin
                                pc_we  = 1'b1;
                                pc_src = PC_SRC_BRANCH;
                            end
                            state_next = ST_FETCH;
                        end
                        CLS_J: begin
                            pc_we      = 1'b1;
                            pc_src     = PC_SRC_JUMP;
                            state_next = ST_FETCH;
                        end
                        CLS_JR: begin
                            pc_we      = 1'b1;
                            pc_src     = PC_SRC_RS;
                            state_next = ST_FETCH;
                        end
                        CLS_JAL: begin
                            pc_we      = 1'b1;
                            pc_src     = PC_SRC_JUMP;
                            state_next = ST_WB;
                        end
                        default: state_next = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    mem_isel = 1'b0;
                    mem_we   = (cls_q == CLS_SW);
                    if (mem_ready) begin
                        state_next = (cls_q == CLS_SW) ? ST_FETCH : ST_WB;
                    end
                end
                ST_WB: begin
                    rf_we = 1'b1;
                    case (cls_q)
                        CLS_IALU: begin
                            rf_wsel = RF_WSEL_RT;
                            wb_sel  = WB_SEL_ALU;
                        end
                        CLS_LW: begin
                            rf_wsel = RF_WSEL_RT;
                            wb_sel  = WB_SEL_MEM;
                        end
                        CLS_JAL: begin
                            rf_wsel = RF_WSEL_RA;
                            wb_sel  = WB_SEL_PC;
                        end
                        default: begin
                            rf_wsel = RF_WSEL_RD;
                            wb_sel  = WB_SEL_ALU;
                        end
                    endcase
                    state_next = ST_FETCH;
                end
                ST_HALT: state_next = ST_HALT;
                default: state_next = ST_FETCH;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    // Cycle and retirement counters; both freeze once the core halts
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state != ST_HALT) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if ((state != ST_FETCH) && (state != ST_HALT) && (state_next == ST_FETCH)) begin
                ret_cnt <= ret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes the expected output
// vector for every cycle it drives; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [26:0] inst_type = '0;
    logic        inst_zero = 1'b0;
    logic        alu_zero  = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_isel, ir_we, pc_we, alu_srcb_imm, rf_we;
    logic [1:0]  pc_src, rf_wsel, wb_sel;
    logic        halted, illegal;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    multicycle_ctrl #(.NOP_SKIP(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_type    (inst_type),
        .inst_zero    (inst_zero),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_isel     (mem_isel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_srcb_imm (alu_srcb_imm),
        .rf_we        (rf_we),
        .rf_wsel      (rf_wsel),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .illegal      (illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cyc_cnt      (cyc_cnt),
        .ret_cnt      (ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [14:0] v;
        logic        perf;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic perf_chk = 1'b0;

    // Packing: {mem_req, mem_we, mem_isel, ir_we, pc_we, pc_src, srcb, rf_we, rf_wsel, wb_sel, halted, illegal}
    function automatic logic [14:0] mk(input logic mreq, input logic mwe, input logic isel,
                                       input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                       input logic srcb, input logic rfwe, input logic [1:0] ws,
                                       input logic [1:0] wb, input logic h, input logic il);
        return {mreq, mwe, isel, irwe, pcwe, pcs, srcb, rfwe, ws, wb, h, il};
    endfunction

    function automatic logic [14:0] ef(input logic r);
        return mk(1, 0, 1, r, r, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0);
    endfunction

    function automatic logic [14:0] eh(input logic il);
        return mk(0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 1, il);
    endfunction

    localparam logic [14:0] Z      = 15'd0;
    localparam logic [14:0] E_IMM  = 15'b000000010000000;
    localparam logic [14:0] M_RD   = 15'b100000000000000;
    localparam logic [14:0] M_WR   = 15'b110000000000000;

    // Drive one cycle of inputs and queue the outputs expected in that cycle
    task automatic st(input string nm, input logic r, input logic [26:0] it, input logic iz,
                      input logic az, input logic mr, input logic [14:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst       = r;
        inst_type = it;
        inst_zero = iz;
        alu_zero  = az;
        mem_ready = mr;
        x.nm   = nm;
        x.v    = e;
        x.perf = perf_chk;
        perf_chk = 1'b0;
        q.push_back(x);
    endtask

    // Monitor: compare DUT outputs against the queued expectation mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [14:0] act;
            e   = q.pop_front();
            act = {mem_req, mem_we, mem_isel, ir_we, pc_we, pc_src, alu_srcb_imm,
                   rf_we, rf_wsel, wb_sel, halted, illegal};
            n_tests++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: outputs got %b expected %b", e.nm, act, e.v);
            end
`ifdef MULTICYCLE_CTRL_PERF_EN
            if (e.perf) begin
                n_tests++;
                if (cyc_cnt !== 32'd0 || ret_cnt !== 32'd0) begin
                    n_fail++;
                    $display("FAIL %s_perf: cyc_cnt=%0d ret_cnt=%0d expected 0 0", e.nm, cyc_cnt, ret_cnt);
                end
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);

        // Reset state: FETCH waiting for memory
        st("reset_fetch", 0, 27'd0, 0, 0, 0, ef(0));

        // ADD: inst_type changed after DECODE to prove the class is latched
        st("add_fetch",  0, 27'd0,     0, 0, 1, ef(1));
        st("add_decode", 0, 27'd1<<0,  0, 0, 0, Z);
        st("add_exec",   0, 27'd1<<21, 0, 0, 0, Z);
        st("add_wb",     0, 27'd1<<21, 0, 0, 0, mk(0,0,0,0,0,2'd0,0,1,2'd0,2'd0,0,0));
        st("add_back",   0, 27'd0,     0, 0, 0, ef(0));

        // LW with three memory wait cycles
        st("lw_fetch",  0, 27'd0,     0, 0, 1, ef(1));
        st("lw_decode", 0, 27'd1<<20, 0, 0, 0, Z);
        st("lw_exec",   0, 27'd0,     0, 0, 0, E_IMM);
        for (int i = 0; i < 3; i++) st("lw_mem_wait", 0, 27'd0, 0, 0, 0, M_RD);
        st("lw_mem_rdy", 0, 27'd0, 0, 0, 1, M_RD);
        st("lw_wb",      0, 27'd0, 0, 0, 0, mk(0,0,0,0,0,2'd0,0,1,2'd1,2'd1,0,0));

        // SW with one wait cycle
        st("sw_fetch",   0, 27'd0,     0, 0, 1, ef(1));
        st("sw_decode",  0, 27'd1<<21, 0, 0, 0, Z);
        st("sw_exec",    0, 27'd0,     0, 0, 0, E_IMM);
        st("sw_mem_wait",0, 27'd0,     0, 0, 0, M_WR);
        st("sw_mem_rdy", 0, 27'd0,     0, 0, 1, M_WR);

        // ADDI
        st("addi_fetch",  0, 27'd0,     0, 0, 1, ef(1));
        st("addi_decode", 0, 27'd1<<15, 0, 0, 0, Z);
        st("addi_exec",   0, 27'd0,     0, 0, 0, E_IMM);
        st("addi_wb",     0, 27'd0,     0, 0, 0, mk(0,0,0,0,0,2'd0,0,1,2'd1,2'd0,0,0));

        // BEQ taken / not taken
        st("beq_t_fetch",  0, 27'd0,     0, 0, 1, ef(1));
        st("beq_t_decode", 0, 27'd1<<22, 0, 0, 0, Z);
        st("beq_t_exec",   0, 27'd0,     0, 1, 0, mk(0,0,0,0,1,2'd1,0,0,2'd0,2'd0,0,0));
        st("beq_n_fetch",  0, 27'd0,     0, 0, 1, ef(1));
        st("beq_n_decode", 0, 27'd1<<22, 0, 0, 0, Z);
        st("beq_n_exec",   0, 27'd0,     0, 0, 0, Z);

        // BNE taken / not taken
        st("bne_t_fetch",  0, 27'd0,     0, 0, 1, ef(1));
        st("bne_t_decode", 0, 27'd1<<23, 0, 0, 0, Z);
        st("bne_t_exec",   0, 27'd0,     0, 0, 0, mk(0,0,0,0,1,2'd1,0,0,2'd0,2'd0,0,0));
        st("bne_n_fetch",  0, 27'd0,     0, 0, 1, ef(1));
        st("bne_n_decode", 0, 27'd1<<23, 0, 0, 0, Z);
        st("bne_n_exec",   0, 27'd0,     0, 1, 0, Z);

        // J, JR, JAL
        st("j_fetch",    0, 27'd0,     0, 0, 1, ef(1));
        st("j_decode",   0, 27'd1<<24, 0, 0, 0, Z);
        st("j_exec",     0, 27'd0,     0, 0, 0, mk(0,0,0,0,1,2'd2,0,0,2'd0,2'd0,0,0));
        st("jr_fetch",   0, 27'd0,     0, 0, 1, ef(1));
        st("jr_decode",  0, 27'd1<<25, 0, 0, 0, Z);
        st("jr_exec",    0, 27'd0,     0, 0, 0, mk(0,0,0,0,1,2'd3,0,0,2'd0,2'd0,0,0));
        st("jal_fetch",  0, 27'd0,     0, 0, 1, ef(1));
        st("jal_decode", 0, 27'd1<<26, 0, 0, 0, Z);
        st("jal_exec",   0, 27'd0,     0, 0, 0, mk(0,0,0,0,1,2'd2,0,0,2'd0,2'd0,0,0));
        st("jal_wb",     0, 27'd0,     0, 0, 0, mk(0,0,0,0,0,2'd0,0,1,2'd2,2'd2,0,0));

        // NOP skips straight back to FETCH
        st("nop_fetch",  0, 27'd0, 0, 0, 1, ef(1));
        st("nop_decode", 0, 27'd0, 1, 0, 0, Z);
        st("nop_back",   0, 27'd0, 0, 0, 0, ef(0));

        // Reset during a FETCH wait abandons the request
        st("rstw_fetch",   0, 27'd0, 0, 0, 0, ef(0));
        st("rstw_reset",   1, 27'd0, 0, 0, 0, Z);
        perf_chk = 1'b1;
        st("rstw_restart", 0, 27'd0, 0, 0, 0, ef(0));

        // Zero encoding with inst_zero=0 halts; memory ready is ignored
        st("stop_fetch",  0, 27'd0, 0, 0, 1, ef(1));
        st("stop_decode", 0, 27'd0, 0, 0, 0, Z);
        for (int i = 0; i < 10; i++) st("stop_halted", 0, 27'd0, 0, 0, 1, eh(0));
        st("stop_reset",  1, 27'd0, 0, 0, 0, eh(0));
        st("stop_after",  0, 27'd0, 0, 0, 0, ef(0));

        // Two bits set: illegal and halt, cleared only by reset
        st("ill_fetch",  0, 27'd0, 0, 0, 1, ef(1));
        st("ill_decode", 0, 27'h3, 0, 0, 0, Z);
        for (int i = 0; i < 3; i++) st("ill_halted", 0, 27'd0, 0, 0, 1, eh(1));
        st("ill_reset",  1, 27'd0, 0, 0, 0, eh(1));
        st("ill_after",  0, 27'd0, 0, 0, 0, ef(0));

        @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
